plot_arbiter: RTL and testbench



---
 rtl/plot_arbiter.sv | 118 +++++++++++
 tb/tb_plot_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/plot_arbiter.sv
// Round-robin owner of the single VGA plot port: one drawing engine holds the port
// per job, its pixel stream is forwarded through registers, and a watchdog reclaims stuck grants.
module plot_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     done,
    input  logic [9*NUM_REQ-1:0]   req_x,
    input  logic [8*NUM_REQ-1:0]   req_y,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    input  logic [NUM_REQ-1:0]     req_plot,
    output logic [NUM_REQ-1:0]     grant,
    output logic [8:0]             vga_x,
    output logic [7:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [2:0]             timeout_id,
    output logic                   dbg_state
);
    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   last, gidx, sel_idx, cand;
    logic            sel_found;
    logic [WW-1:0]   wd;
    logic            wd_hit, rel, to_rel;

    assign busy      = (state_q == ACTIVE);
    assign dbg_state = state_q;

    // Search starts one past the last owner so every pending engine is served before a repeat.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = last;
        cand      = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = LW'((int'(last) + k) % NUM_REQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wd_hit  = (wd == WW'(TIMEOUT - 1));
        rel     = 1'b0;
        to_rel  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) state_d = ACTIVE;
            end
            ACTIVE: begin
                rel    = done[gidx] || !req[gidx] || wd_hit;
                // A completion or abandon landing on the last allowed cycle is not an error.
                to_rel = wd_hit && !done[gidx] && req[gidx];
                if (rel) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last        <= LW'(NUM_REQ - 1);
            gidx        <= '0;
            wd          <= '0;
            grant       <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    vga_plot <= 1'b0;
                    if (sel_found) begin
                        grant <= ONE_HOT0 << sel_idx;
                        gidx  <= sel_idx;
                        wd    <= '0;
                    end
                end
                ACTIVE: begin
                    if (rel) begin
                        grant    <= '0;
                        last     <= gidx;
                        vga_plot <= 1'b0;
                        if (to_rel) begin
                            timeout_err <= 1'b1;
                            timeout_id  <= 3'(gidx);
                        end
                    end else begin
                        vga_x      <= req_x[9*gidx +: 9];
                        vga_y      <= req_y[8*gidx +: 8];
                        vga_colour <= req_colour[3*gidx +: 3];
                        vga_plot   <= req_plot[gidx];
                        wd         <= wd + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: a long-timeout instance for streaming/arbitration
// and a TIMEOUT=16 instance on the same inputs for the watchdog cases.
module tb_plot_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, done, req_plot;
    logic [9*N-1:0] req_x;
    logic [8*N-1:0] req_y;
    logic [3*N-1:0] req_colour;

    logic [N-1:0] grant, t_grant;
    logic [8:0]   vga_x, t_vga_x;
    logic [7:0]   vga_y, t_vga_y;
    logic [2:0]   vga_colour, t_vga_colour;
    logic         vga_plot, t_vga_plot, busy, t_busy;
    logic         timeout_err, t_timeout_err, dbg_state, t_dbg_state;
    logic [2:0]   timeout_id, t_timeout_id;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] exp_grant;
    } rr_vec_t;
    rr_vec_t rr_tab[17];

    always #5 clk = ~clk;

    plot_arbiter #(.NUM_REQ(N), .TIMEOUT(64)) u_dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .req_plot(req_plot), .grant(grant), .vga_x(vga_x),
        .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
        .timeout_err(timeout_err), .timeout_id(timeout_id), .dbg_state(dbg_state));

    plot_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) u_to (
        .clk(clk), .reset(reset), .req(req), .done(done), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .req_plot(req_plot), .grant(t_grant), .vga_x(t_vga_x),
        .vga_y(t_vga_y), .vga_colour(t_vga_colour), .vga_plot(t_vga_plot), .busy(t_busy),
        .timeout_err(t_timeout_err), .timeout_id(t_timeout_id), .dbg_state(t_dbg_state));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int i, input logic [8:0] x, input logic [7:0] y,
                           input logic [2:0] c, input logic p);
        req_x[9*i +: 9]      = x;
        req_y[8*i +: 8]      = y;
        req_colour[3*i +: 3] = c;
        req_plot[i]          = p;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0; done = '0; req_plot = '0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req = '0; done = '0; req_plot = '0;
        req_x = '0; req_y = '0; req_colour = '0;

        rr_tab[0]  = '{4'b1111, 4'b0000, 4'b0001};
        rr_tab[1]  = '{4'b1111, 4'b0000, 4'b0001};
        rr_tab[2]  = '{4'b1111, 4'b0000, 4'b0001};
        rr_tab[3]  = '{4'b1111, 4'b0001, 4'b0000};
        rr_tab[4]  = '{4'b1111, 4'b0000, 4'b0010};
        rr_tab[5]  = '{4'b1111, 4'b0000, 4'b0010};
        rr_tab[6]  = '{4'b1111, 4'b0000, 4'b0010};
        rr_tab[7]  = '{4'b1111, 4'b0010, 4'b0000};
        rr_tab[8]  = '{4'b1111, 4'b0000, 4'b0100};
        rr_tab[9]  = '{4'b1111, 4'b0000, 4'b0100};
        rr_tab[10] = '{4'b1111, 4'b0000, 4'b0100};
        rr_tab[11] = '{4'b1111, 4'b0100, 4'b0000};
        rr_tab[12] = '{4'b1111, 4'b0000, 4'b1000};
        rr_tab[13] = '{4'b1111, 4'b0000, 4'b1000};
        rr_tab[14] = '{4'b1111, 4'b0000, 4'b1000};
        rr_tab[15] = '{4'b1111, 4'b1000, 4'b0000};
        rr_tab[16] = '{4'b1111, 4'b0000, 4'b0001};

        // Reset state
        step(); step();
        check("rst_grant", grant, 0);
        check("rst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
        check("rst_busy", busy, 0);
        check("rst_err", {timeout_err, timeout_id}, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;

        // Single job: requester 1 streams x=10..41
        req = 4'b0010;
        step();
        check("single_grant", grant, 4'b0010);
        check("single_busy", busy, 1);
        check("single_noplot", vga_plot, 0);
        for (int i = 0; i < 32; i++) begin
            set_pix(1, 9'(10 + i), 8'd50, 3'd5, 1'b1);
            exp_q.push_back(9'(10 + i));
            step();
            check("single_x", vga_x, exp_q.pop_front());
            check("single_yc", {vga_y, vga_colour, vga_plot}, {8'd50, 3'd5, 1'b1});
        end
        done = 4'b0010;
        set_pix(1, 9'd42, 8'd51, 3'd2, 1'b1);
        step();
        check("single_rel_grant", grant, 0);
        check("single_rel_plot", vga_plot, 0);
        check("single_rel_busy", busy, 0);
        check("single_rel_xhold", vga_x, 41);
        check("single_rel_err", timeout_err, 0);
        done = '0; req = '0; set_pix(1, 9'd0, 8'd0, 3'd0, 1'b0);
        step();
        check("single_idle", {grant, vga_plot, busy}, 0);

        // Round-robin table
        do_reset();
        for (int r = 0; r < 17; r++) begin
            req  = rr_tab[r].req;
            done = rr_tab[r].done;
            step();
            check($sformatf("rr_grant_%0d", r), grant, rr_tab[r].exp_grant);
            check($sformatf("rr_busy_%0d", r), busy, |rr_tab[r].exp_grant);
        end

        // Isolation: requester 0 noise while requester 2 owns the port
        do_reset();
        req = 4'b0100;
        step();
        check("iso_grant0", grant, 4'b0100);
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            set_pix(0, 9'd300, 8'd1, 3'd7, 1'b1);
            set_pix(2, 9'(100 + i), 8'd20, 3'd3, 1'b1);
            done = 4'b0001;
            step();
            check("iso_grant", grant, 4'b0100);
            check("iso_x", vga_x, 100 + i);
        end
        done = 4'b0100;
        step();
        check("iso_rel", grant, 0);
        done = '0; req = 4'b0001;
        step();
        check("iso_next", grant, 4'b0001);
        req = '0; req_plot = '0;

        // Watchdog expiry on the TIMEOUT=16 instance
        do_reset();
        req = 4'b1000;
        step();
        check("to_grant", t_grant, 4'b1000);
        req = 4'b1001;
        for (int k = 1; k <= 15; k++) begin
            step();
            check("to_hold", t_grant, 4'b1000);
        end
        check("to_err_pre", t_timeout_err, 0);
        step();
        check("to_drop", t_grant, 0);
        check("to_err", t_timeout_err, 1);
        check("to_id", t_timeout_id, 3);
        req = 4'b0001;
        step();
        check("to_next", t_grant, 4'b0001);
        done = 4'b0001;
        step();
        check("to_sticky", {t_grant, t_timeout_err, t_timeout_id}, {4'b0000, 1'b1, 3'd3});
        done = '0;

        // Done coinciding with watchdog expiry is a normal completion
        do_reset();
        req = 4'b0001;
        step();
        for (int k = 1; k <= 15; k++) step();
        check("tod_hold", t_grant, 4'b0001);
        done = 4'b0001;
        step();
        check("tod_drop", t_grant, 0);
        check("tod_noerr", t_timeout_err, 0);
        done = '0; req = '0;

        // Abandon, then reset mid-job
        do_reset();
        req = 4'b0010;
        step(); step(); step();
        check("ab_grant", grant, 4'b0010);
        req = 4'b0000;
        step();
        check("ab_drop", {grant, busy}, 0);
        check("ab_noerr", timeout_err, 0);
        req = 4'b0100;
        step();
        check("ab_g2", grant, 4'b0100);
        set_pix(2, 9'd77, 8'd9, 3'd6, 1'b1);
        step();
        check("ab_pix", {vga_x, vga_plot}, {9'd77, 1'b1});
        reset = 1'b1;
        step();
        check("mid_rst_grant", {grant, busy}, 0);
        check("mid_rst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
        check("mid_rst_err", {timeout_err, timeout_id}, 0);
        reset = 1'b0;
        step();
        check("post_rst_grant", grant, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
